// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the 8-digit binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int          BIN_W_DEF = 27;
    localparam int          DIGITS    = 8;
    localparam logic [26:0] MAX_VAL   = 27'd99_999_999;
    localparam logic [31:0] BCD_SAT   = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj (
    input  logic [3:0] din_i,
    output logic [3:0] dout_o
);

    // A digit is at most 9 here, so the 4-bit sum never carries out.
    assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule

// File: rtl/bin2bcd_8dig.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, with
// leading-zero blanking and optional saturation for the 8-digit display bank.
module bin2bcd_8dig
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = BIN_W_DEF,
    parameter bit BLANK_EN = 1'b1,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [BIN_W-1:0] iBIN,
    input  logic             iSTART,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oOVF,
    output logic [31:0]      oDIG,
    output logic [7:0]       oON_OFF
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int DIG_W = 4 * DIGITS;
    localparam int ACC_W = DIG_W + 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [DIGITS-1:0]   on_q, on_d;
    logic                ovfo_q, ovfo_d;
    logic                done_q, done_d;

    logic [ACC_W-1:0]    adj_w;
    logic                in_ovf_w;
    logic [DIG_W-1:0]    fin_dig_w;
    logic [DIGITS-1:0]   fin_on_w;
    logic                seen_w;

    assign in_ovf_w = 32'(iBIN) > 32'(MAX_VAL);

    // The ninth nibble holds the 10^8 digit that a 27-bit value can reach.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din_i  (acc_q[4*g +: 4]),
            .dout_o (adj_w[4*g +: 4])
        );
    end

    always_comb begin
        fin_dig_w = (SAT_EN && ovf_q) ? BCD_SAT : acc_q[DIG_W-1:0];
        fin_on_w  = '0;
        seen_w    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            seen_w = seen_w | (fin_dig_w[4*(DIGITS-1-i) +: 4] != 4'd0);
            fin_on_w[DIGITS-1-i] = seen_w | !BLANK_EN;
        end
        fin_on_w[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        on_d    = on_q;
        ovfo_d  = ovfo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    bin_d   = iBIN;
                    acc_d   = '0;
                    ovf_d   = in_ovf_w;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = {adj_w, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                dig_d   = fin_dig_w;
                on_d    = fin_on_w;
                ovfo_d  = ovf_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
            on_q    <= DIGITS'(1);
            ovfo_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            on_q    <= on_d;
            ovfo_q  <= ovfo_d;
            done_q  <= done_d;
        end
    end

    assign oBUSY   = (state_q != IDLE);
    assign oDONE   = done_q;
    assign oOVF    = ovfo_q;
    assign oDIG    = dig_q;
    assign oON_OFF = on_q;

endmodule
